uart_alu_parser: RTL

Byte-stream packet parser sitting directly downstream of `uart_rx` inside `uart_alu`. It consumes received bytes over an AXI-Stream-style handshake and decodes the 4-byte header (opcode, reserved, 16-bit length). It assembles the payload into little-endian 32-bit words and presents them, tagged with opcode and first/last markers, to the ALU/echo execution stage. It also detects malformed packets and stalled transfers, and resynchronises to the next header.

---
 rtl/uart_alu_pkg.sv | 37 +++
 rtl/uart_alu_parser_if.sv | 31 +++
 rtl/uart_alu_timeout.sv | 30 +++
 rtl/uart_alu_parser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the uart_alu parser and execution stages:
// opcodes, error codes, parser states and header size.
package uart_alu_pkg;

   localparam int HDR_BYTES = 4;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'h88;
   localparam logic [7:0] OP_DIV  = 8'hD1;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_BAD_OP  = 2'b01,
      ERR_BAD_LEN = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RSVD    = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_LEN_HI  = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_DROP    = 3'd5
   } parser_state_e;

   // Arithmetic opcodes carry whole 32-bit operands only.
   function automatic logic is_arith_op(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_known_op(input logic [7:0] op);
      return (op == OP_ECHO) || is_arith_op(op);
   endfunction

endpackage

// File: rtl/uart_alu_parser_if.sv
// Byte-stream input and word-stream output of the packet parser.
// The parser sits on the slave modport; uart_rx / execution side on master.
interface uart_alu_parser_if;
   import uart_alu_pkg::*;

   logic [7:0]  s_axis_tdata_i;
   logic        s_axis_tvalid_i;
   logic        s_axis_tready_o;
   logic [7:0]  op_o;
   logic [31:0] word_o;
   logic [2:0]  nbytes_o;
   logic        first_o;
   logic        last_o;
   logic        valid_o;
   logic        ready_i;
   logic        err_o;
   logic [1:0]  err_code_o;

   modport slave (
      input  s_axis_tdata_i, s_axis_tvalid_i, ready_i,
      output s_axis_tready_o, op_o, word_o, nbytes_o, first_o, last_o,
             valid_o, err_o, err_code_o
   );

   modport master (
      output s_axis_tdata_i, s_axis_tvalid_i, ready_i,
      input  s_axis_tready_o, op_o, word_o, nbytes_o, first_o, last_o,
             valid_o, err_o, err_code_o
   );

endinterface

// File: rtl/uart_alu_timeout.sv
// Stall timer: counts enabled cycles, pulses expire on the cycle the count
// reaches TIMEOUT_CYCLES-1, then restarts from zero.
module uart_alu_timeout #(
   parameter int TIMEOUT_CYCLES = 125000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   assign expire = en && (cnt_q == TC);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr || expire) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_alu_parser.sv
// Packet parser: decodes the 4-byte header, packs payload into LE words,
// drops malformed packets and aborts stalled ones.
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  ST_IDLE    | waiting for opcode byte
//  ST_RSVD    | discarding reserved byte
//  ST_LEN_LO  | capturing LEN[7:0]
//  ST_LEN_HI  | capturing LEN[15:8], validating header
//  ST_PAYLOAD | assembling payload words, rem bytes left
//  ST_DROP    | discarding rem bytes of a rejected packet
module uart_alu_parser
   import uart_alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 125000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   uart_alu_parser_if.slave bus
);

   parser_state_e state_q, state_n;
   logic [7:0]  op_q, op_n;
   logic [7:0]  len_lo_q, len_lo_n;
   logic [15:0] rem_q, rem_n;
   logic [1:0]  k_q, k_n;
   logic [31:0] acc_q, acc_n;
   logic        first_flag_q, first_flag_n;
   logic [31:0] word_q, word_n;
   logic [2:0]  nbytes_q, nbytes_n;
   logic        first_q, first_n;
   logic        last_q, last_n;
   logic        valid_q, valid_n;
   logic        err_q, err_n;
   err_code_e   err_code_q, err_code_n;

   logic        tready, accept;
   logic        tmr_clr, tmr_en, tmr_expire;
   logic [15:0] len_full, payload_len, rem_dec;
   logic [31:0] acc_byte;

   assign tready  = !rst_i && !valid_q;
   assign accept  = bus.s_axis_tvalid_i && tready;
   assign tmr_en  = (state_q != ST_IDLE) && tready && !accept;
   assign tmr_clr = accept || (state_q == ST_IDLE);

   assign len_full    = {bus.s_axis_tdata_i, len_lo_q};
   assign payload_len = len_full - 16'(HDR_BYTES);
   assign rem_dec     = rem_q - 16'd1;

   always_comb begin
      acc_byte = acc_q;
      acc_byte[{k_q, 3'b000} +: 8] = bus.s_axis_tdata_i;
   end

   uart_alu_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   always_comb begin
      state_n      = state_q;
      op_n         = op_q;
      len_lo_n     = len_lo_q;
      rem_n        = rem_q;
      k_n          = k_q;
      acc_n        = acc_q;
      first_flag_n = first_flag_q;
      word_n       = word_q;
      nbytes_n     = nbytes_q;
      first_n      = first_q;
      last_n       = last_q;
      valid_n      = valid_q;
      err_n        = 1'b0;
      err_code_n   = err_code_q;

      if (valid_q && bus.ready_i) valid_n = 1'b0;

      if (tmr_expire) begin
         state_n      = ST_IDLE;
         rem_n        = '0;
         k_n          = '0;
         acc_n        = '0;
         first_flag_n = 1'b0;
         err_n        = 1'b1;
         err_code_n   = ERR_TIMEOUT;
      end else if (accept) begin
         unique case (state_q)
            ST_IDLE: begin
               op_n    = bus.s_axis_tdata_i;
               state_n = ST_RSVD;
            end
            ST_RSVD: state_n = ST_LEN_LO;
            ST_LEN_LO: begin
               len_lo_n = bus.s_axis_tdata_i;
               state_n  = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               k_n   = '0;
               acc_n = '0;
               rem_n = payload_len;
               if (len_full < 16'd5) begin
                  err_n      = 1'b1;
                  err_code_n = ERR_BAD_LEN;
                  rem_n      = '0;
                  state_n    = ST_IDLE;
               end else if (!is_known_op(op_q)) begin
                  err_n      = 1'b1;
                  err_code_n = ERR_BAD_OP;
                  state_n    = ST_DROP;
               end else if (is_arith_op(op_q) && (payload_len[1:0] != 2'b00)) begin
                  err_n      = 1'b1;
                  err_code_n = ERR_BAD_LEN;
                  state_n    = ST_DROP;
               end else begin
                  first_flag_n = 1'b1;
                  state_n      = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               rem_n = rem_dec;
               if ((k_q == 2'd3) || (rem_dec == 16'd0)) begin
                  word_n       = acc_byte;
                  nbytes_n     = {1'b0, k_q} + 3'd1;
                  first_n      = first_flag_q;
                  last_n       = (rem_dec == 16'd0);
                  valid_n      = 1'b1;
                  first_flag_n = 1'b0;
                  k_n          = '0;
                  acc_n        = '0;
                  if (rem_dec == 16'd0) state_n = ST_IDLE;
               end else begin
                  acc_n = acc_byte;
                  k_n   = k_q + 2'd1;
               end
            end
            ST_DROP: begin
               rem_n = rem_dec;
               if (rem_dec == 16'd0) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         len_lo_q     <= '0;
         rem_q        <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         first_flag_q <= 1'b0;
         word_q       <= '0;
         nbytes_q     <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_n;
         op_q         <= op_n;
         len_lo_q     <= len_lo_n;
         rem_q        <= rem_n;
         k_q          <= k_n;
         acc_q        <= acc_n;
         first_flag_q <= first_flag_n;
         word_q       <= word_n;
         nbytes_q     <= nbytes_n;
         first_q      <= first_n;
         last_q       <= last_n;
         valid_q      <= valid_n;
         err_q        <= err_n;
         err_code_q   <= err_code_n;
      end
   end

   assign bus.s_axis_tready_o = tready;
   assign bus.op_o            = op_q;
   assign bus.word_o          = word_q;
   assign bus.nbytes_o        = nbytes_q;
   assign bus.first_o         = first_q;
   assign bus.last_o          = last_q;
   assign bus.valid_o         = valid_q;
   assign bus.err_o           = err_q;
   assign bus.err_code_o      = err_code_q;

endmodule
